// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types plus responder-local FSM state and LFSR seed.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [15:0] DBUS_RESP_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dbus_resp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when step=1.
// Latency: new value visible the cycle after step; reloads the seed on reset.
// Backpressure: none; step is a simple enable.
// Ports: clk, reset (sync, active-high), step (advance enable), lfsr[15:0] (current value).
module dbus_resp_lfsr
    import dbus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] lfsr
);

    logic feedback;

    // Tap positions 16,14,13,11 correspond to bits 15,13,12,10.
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= DBUS_RESP_LFSR_SEED;
        end else if (step) begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder backed by a word-addressed 64-bit RAM with byte-strobe writes.
// Latency: LATENCY+1 cycles from accept to data_ok (LFSR-chosen 1..16 with DBUS_RAND_LATENCY_EN).
// Backpressure: one access in flight; new requests accepted only in IDLE (spacing LATENCY+2).
// Ports: clk, reset (sync, active-high), dreq (request), dresp (addr_ok/data_ok/data),
//        oob_cnt (saturating out-of-range access count).
// Optional macro DBUS_RAND_LATENCY_EN: per-request latency from dbus_resp_lfsr, LATENCY ignored.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [15:0] oob_cnt
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    logic [63:0] mem [0:MEM_WORDS-1];

    resp_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic [3:0]  lat_sel;

    logic [63:0] lat_addr;
    logic [63:0] lat_data;
    logic [7:0]  lat_strobe;
    msize_t      lat_size;

    logic [63:0]      off;
    logic             in_range;
    logic             is_wr;
    logic [IDX_W-1:0] idx;

    // Size is carried for completeness but strobe alone selects written lanes.
    logic unused_bits;

`ifdef DBUS_RAND_LATENCY_EN
    logic [15:0] lfsr_val;

    dbus_resp_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (accept),
        .lfsr  (lfsr_val)
    );

    assign lat_sel     = lfsr_val[3:0];
    assign unused_bits = ^{lat_size, lfsr_val[15:4]};
`else
    assign lat_sel     = 4'(LATENCY);
    assign unused_bits = ^lat_size;
`endif

    // Address decode on the latched request; subtraction wraps so addresses
    // below BASE_ADDR land far out of range.
    assign off      = lat_addr - BASE_ADDR;
    assign in_range = (off < MEM_BYTES);
    assign idx      = off[IDX_W+2:3];
    assign is_wr    = (lat_strobe != 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        dresp     = '0;
        case (state)
            IDLE: begin
                if (dreq.valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = lat_sel;
                    state_nxt = (lat_sel == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                if (!is_wr && in_range) begin
                    dresp.data = mem[idx];
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr   <= 64'd0;
            lat_data   <= 64'd0;
            lat_strobe <= 8'd0;
            lat_size   <= MSIZE1;
        end else if (accept) begin
            lat_addr   <= dreq.addr;
            lat_data   <= dreq.data;
            lat_strobe <= dreq.strobe;
            lat_size   <= dreq.size;
        end
    end

    // RAM has no reset; a reset coinciding with RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && is_wr && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (lat_strobe[i]) begin
                    mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_cnt <= 16'd0;
        end else if (state == RESP && !in_range && oob_cnt != 16'hFFFF) begin
            oob_cnt <= oob_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk;
    logic        reset_a, reset_b;
    dbus_req_t   dreq_a, dreq_b;
    dbus_resp_t  dresp_a, dresp_b;
    logic [15:0] oob_cnt_a, oob_cnt_b;

    int total;
    int bad;

`ifdef DBUS_RAND_LATENCY_EN
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction
`endif

    dbus_responder #(.MEM_WORDS(4096), .LATENCY(LAT_A), .BASE_ADDR(64'h8000_0000)) u_dut_a (
        .clk     (clk),
        .reset   (reset_a),
        .dreq    (dreq_a),
        .dresp   (dresp_a),
        .oob_cnt (oob_cnt_a)
    );

    dbus_responder #(.MEM_WORDS(4096), .LATENCY(LAT_B), .BASE_ADDR(64'h8000_0000)) u_dut_b (
        .clk     (clk),
        .reset   (reset_b),
        .dreq    (dreq_b),
        .dresp   (dresp_b),
        .oob_cnt (oob_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on DUT A: checks idle outputs each cycle, the latency, the
    // response data, and that the cycle after data_ok is quiet again.
    task automatic acc_a(input logic [63:0] addr, input logic [7:0] strb,
                         input logic [63:0] wdat, input logic [63:0] exp_data,
                         input string name);
        int  exp_lat;
        bit  done;
`ifdef DBUS_RAND_LATENCY_EN
        exp_lat = int'(lfsr_m[3:0]) + 1;
        lfsr_m  = lfsr_step(lfsr_m);
`else
        exp_lat = LAT_A + 1;
`endif
        @(posedge clk); #1;
        dreq_a.valid  = 1'b1;
        dreq_a.addr   = addr;
        dreq_a.size   = MSIZE8;
        dreq_a.strobe = strb;
        dreq_a.data   = wdat;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (dresp_a.data_ok) begin
                total++;
                if (cyc !== exp_lat) begin
                    bad++;
                    $display("FAIL %s latency got=%0d exp=%0d", name, cyc, exp_lat);
                end
                total++;
                if (dresp_a.addr_ok !== 1'b1) begin
                    bad++;
                    $display("FAIL %s addr_ok got=%b exp=1", name, dresp_a.addr_ok);
                end
                total++;
                if (dresp_a.data !== exp_data) begin
                    bad++;
                    $display("FAIL %s data got=%h exp=%h", name, dresp_a.data, exp_data);
                end
                dreq_a.valid = 1'b0;
                done = 1'b1;
            end else begin
                total++;
                if (dresp_a.data !== 64'd0 || dresp_a.addr_ok !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle_cycle%0d data=%h addr_ok=%b exp 0/0",
                             name, cyc, dresp_a.data, dresp_a.addr_ok);
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            dreq_a.valid = 1'b0;
            $display("FAIL %s timeout no data_ok within 40 cycles", name);
        end else begin
            @(negedge clk);
            total++;
            if (dresp_a.data_ok !== 1'b0 || dresp_a.data !== 64'd0) begin
                bad++;
                $display("FAIL %s after_resp data_ok=%b data=%h exp 0/0",
                         name, dresp_a.data_ok, dresp_a.data);
            end
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        dreq_a  = '0;
        dreq_b  = '0;
`ifdef DBUS_RAND_LATENCY_EN
        lfsr_m = DBUS_RESP_LFSR_SEED;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        total++;
        if (dresp_a !== '0 || oob_cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL reset_a dresp=%h oob=%0d exp 0/0", dresp_a, oob_cnt_a);
        end
        total++;
        if (dresp_b !== '0 || oob_cnt_b !== 16'd0) begin
            bad++;
            $display("FAIL reset_b dresp=%h oob=%0d exp 0/0", dresp_b, oob_cnt_b);
        end
    endtask

    task automatic test_basic_read();
        acc_a(64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, "preload_w0");
        acc_a(64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, "basic_read");
    endtask

    task automatic test_partial_write();
        acc_a(64'h8000_0010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "preload_w2");
        acc_a(64'h8000_0010, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, "partial_write");
        acc_a(64'h8000_0010, 8'h00, 64'd0, 64'hFFFF_FFFF_CCCC_DDDD, "partial_read");
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        dreq_b.valid  = 1'b1;
        dreq_b.addr   = 64'h8000_0008;
        dreq_b.size   = MSIZE8;
        dreq_b.strobe = 8'hFF;
        dreq_b.data   = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        total++;
        if (dresp_b.data_ok !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cyc0 data_ok got=%b exp=0", dresp_b.data_ok);
        end
        @(negedge clk);
        total++;
        if (dresp_b.data_ok !== 1'b1 || dresp_b.addr_ok !== 1'b1 || dresp_b.data !== 64'd0) begin
            bad++;
            $display("FAIL b2b_cyc1 ok=%b%b data=%h exp 11/0",
                     dresp_b.addr_ok, dresp_b.data_ok, dresp_b.data);
        end
        dreq_b.strobe = 8'h00;
        dreq_b.data   = 64'd0;
        @(negedge clk);
        total++;
        if (dresp_b.data_ok !== 1'b0 || dresp_b.addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cyc2 ok=%b%b exp 00", dresp_b.addr_ok, dresp_b.data_ok);
        end
        @(negedge clk);
        total++;
        if (dresp_b.data_ok !== 1'b1 || dresp_b.data !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL b2b_cyc3 data_ok=%b data=%h exp 1/0123456789abcdef",
                     dresp_b.data_ok, dresp_b.data);
        end
        dreq_b.valid = 1'b0;
        @(negedge clk);
        total++;
        if (dresp_b.data_ok !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cyc4 data_ok got=%b exp=0", dresp_b.data_ok);
        end
    endtask

    task automatic test_out_of_range();
        acc_a(64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, "oob_read");
        acc_a(64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, "oob_write");
        total++;
        if (oob_cnt_a !== 16'd2) begin
            bad++;
            $display("FAIL oob_cnt got=%0d exp=2", oob_cnt_a);
        end
        acc_a(64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, "oob_ram_intact");
    endtask

    task automatic test_reset_mid_write();
        acc_a(64'h8000_0018, 8'hFF, 64'h5555_6666_7777_8888, 64'd0, "preload_w3");
        @(posedge clk); #1;
        dreq_a.valid  = 1'b1;
        dreq_a.addr   = 64'h8000_0018;
        dreq_a.size   = MSIZE8;
        dreq_a.strobe = 8'hFF;
        dreq_a.data   = 64'h9999_AAAA_BBBB_CCCC;
        @(posedge clk); #1;
        reset_a      = 1'b1;
        dreq_a.valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (dresp_a !== '0 || oob_cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid dresp=%h oob=%0d exp 0/0", dresp_a, oob_cnt_a);
        end
        @(posedge clk); #1;
        reset_a = 1'b0;
`ifdef DBUS_RAND_LATENCY_EN
        lfsr_m = DBUS_RESP_LFSR_SEED;
`endif
        acc_a(64'h8000_0018, 8'h00, 64'd0, 64'h5555_6666_7777_8888, "reset_mid_old");
    endtask

`ifdef DBUS_RAND_LATENCY_EN
    task automatic test_rand_latency();
        @(posedge clk); #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
        lfsr_m  = DBUS_RESP_LFSR_SEED;
        for (int n = 0; n < 100; n++) begin
            if (n % 2 == 0)
                acc_a(64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, "rand_w0");
            else
                acc_a(64'h8000_0010, 8'h00, 64'd0, 64'hFFFF_FFFF_CCCC_DDDD, "rand_w2");
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_read();
        test_partial_write();
`ifndef DBUS_RAND_LATENCY_EN
        test_back_to_back();
`endif
        test_out_of_range();
        test_reset_mid_write();
`ifdef DBUS_RAND_LATENCY_EN
        test_rand_latency();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
